muldiv_unit: RTL and testbench

Parametrised multiply/divide unit with HI/LO registers. It sits beside the ALU in the EX stage and generalises the fixed 32-bit multi-cycle multiplier/divider. Data width and the multiply and divide latencies are configurable, and it adds cancellation and a completion pulse. The hazard unit stalls HI/LO readers and further starts while `start | busy` is high.

---
 rtl/muldiv_unit.sv | 154 +++++++++++++++
 tb/tb_muldiv_unit.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle multiply/divide unit with HI/LO registers.
// The result is computed when the operation is launched and held until the
// latency counter expires, so HI/LO change only in the done cycle.
// Optional feature macro: MULDIV_MADD_EN (ops 6/7 become MADD/MSUB).
module muldiv_unit #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic             cancel,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CW      = $clog2(MAX_LAT + 1);
  localparam logic [CW-1:0]    MUL_CNT = CW'(MUL_LAT);
  localparam logic [CW-1:0]    DIV_CNT = CW'(DIV_LAT);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic {S_IDLE, S_RUN} state_e;
  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5,
    OP_MADD  = 3'd6,
    OP_MSUB  = 3'd7
  } op_e;

  state_e               state, state_n;
  logic [CW-1:0]        cnt, cnt_n;
  logic [2*WIDTH-1:0]   res, res_n;
  logic [WIDTH-1:0]     hi_n, lo_n;
  logic                 busy_n, done_n;

  logic signed [2*WIDTH-1:0] a_ext, b_ext;
  logic [2*WIDTH-1:0]        prod_s, prod_u;
  logic signed [WIDTH-1:0]   sa, sb;
  logic [WIDTH-1:0]          q_s, r_s, q_u, r_u;
  logic [2*WIDTH-1:0]        div_s_res, div_u_res;

  // Full-width products and quotient/remainder pairs with the corner cases
  // (divide by zero, signed MIN / -1) forced to their architectural values.
  always_comb begin
    a_ext  = {{WIDTH{src_a[WIDTH-1]}}, src_a};
    b_ext  = {{WIDTH{src_b[WIDTH-1]}}, src_b};
    prod_s = a_ext * b_ext;
    prod_u = {{WIDTH{1'b0}}, src_a} * {{WIDTH{1'b0}}, src_b};
    sa     = src_a;
    sb     = src_b;
    q_s    = sa / sb;
    r_s    = sa % sb;
    q_u    = src_a / src_b;
    r_u    = src_a % src_b;
    if (src_b == '0) begin
      div_s_res = {src_a, {WIDTH{1'b1}}};
      div_u_res = {src_a, {WIDTH{1'b1}}};
    end else begin
      div_u_res = {r_u, q_u};
      if (src_a == MIN_VAL && src_b == '1)
        div_s_res = {{WIDTH{1'b0}}, MIN_VAL};
      else
        div_s_res = {r_s, q_s};
    end
  end

`ifdef MULDIV_MADD_EN
  logic [2*WIDTH-1:0] acc_res;

  // Accumulate into {HI,LO}; op[0] selects subtract (MSUB) over add (MADD).
  always_comb begin
    acc_res = op[0] ? ({hi, lo} - prod_s) : ({hi, lo} + prod_s);
  end
`endif

  // Next-state, launch and HI/LO write logic; cancel beats any start.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    res_n   = res;
    hi_n    = hi;
    lo_n    = lo;
    done_n  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start && !cancel) begin
          case (op_e'(op))
            OP_MULT:  begin res_n = prod_s;    cnt_n = MUL_CNT; state_n = S_RUN; end
            OP_MULTU: begin res_n = prod_u;    cnt_n = MUL_CNT; state_n = S_RUN; end
            OP_DIV:   begin res_n = div_s_res; cnt_n = DIV_CNT; state_n = S_RUN; end
            OP_DIVU:  begin res_n = div_u_res; cnt_n = DIV_CNT; state_n = S_RUN; end
            OP_MTHI:  hi_n = src_a;
            OP_MTLO:  lo_n = src_a;
`ifdef MULDIV_MADD_EN
            OP_MADD, OP_MSUB: begin res_n = acc_res; cnt_n = MUL_CNT; state_n = S_RUN; end
`endif
            default: ;
          endcase
        end
      end
      S_RUN: begin
        if (cancel) begin
          state_n = S_IDLE;
          cnt_n   = '0;
        end else if (cnt == CW'(1)) begin
          {hi_n, lo_n} = res;
          done_n       = 1'b1;
          state_n      = S_IDLE;
          cnt_n        = '0;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      default: begin
        state_n = S_IDLE;
        cnt_n   = '0;
      end
    endcase
    busy_n = (state_n == S_RUN);
  end

  // State, counter, result holding register and HI/LO with async active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      res   <= '0;
      hi    <= '0;
      lo    <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      res   <= res_n;
      hi    <= hi_n;
      lo    <= lo_n;
      busy  <= busy_n;
      done  <= done_n;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit (WIDTH=32, MUL_LAT=5, DIV_LAT=10).
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic        cancel;
  logic [31:0] src_a, src_b;
  logic [31:0] hi, lo;
  logic        busy, done;

  int checks = 0;
  int errors = 0;
  int n;
  logic d;
  logic seen_done;

  muldiv_unit #(.WIDTH(32), .MUL_LAT(5), .DIV_LAT(10)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .cancel(cancel),
    .src_a(src_a), .src_b(src_b), .hi(hi), .lo(lo), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present a start for one edge; returns 1 time unit after that edge.
  task automatic launch(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; op = o; src_a = a; src_b = b;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Count busy cycles sampled on falling edges; returns at the first sample
  // with busy low, reporting done there. Bounded so a stuck busy cannot hang.
  task automatic wait_done(output int cnt, output logic dn);
    cnt = 0;
    @(negedge clk);
    while (busy && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    dn = done;
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; op = 3'd0; cancel = 1'b0; src_a = '0; src_b = '0;
    #12;
    chk("reset_hi", 64'(hi), 64'h0);
    chk("reset_lo", 64'(lo), 64'h0);
    chk("reset_busy", 64'(busy), 64'h0);
    chk("reset_done", 64'(done), 64'h0);
    @(negedge clk) reset = 1'b1;
    @(negedge clk);

    // MULT -2 * 3 = -6
    launch(3'd0, 32'hFFFFFFFE, 32'h3);
    wait_done(n, d);
    chk("mult_busy_cycles", 64'(n), 64'd5);
    chk("mult_done", 64'(d), 64'h1);
    chk("mult_hi", 64'(hi), 64'hFFFFFFFF);
    chk("mult_lo", 64'(lo), 64'hFFFFFFFA);

    // MULTU launched in the done cycle (back-to-back)
    launch(3'd1, 32'hFFFFFFFE, 32'h3);
    chk("multu_accepted_b2b", 64'(busy), 64'h1);
    chk("done_one_cycle", 64'(done), 64'h0);
    wait_done(n, d);
    chk("multu_busy_cycles", 64'(n), 64'd5);
    chk("multu_done", 64'(d), 64'h1);
    chk("multu_hi", 64'(hi), 64'h00000002);
    chk("multu_lo", 64'(lo), 64'hFFFFFFFA);
    @(negedge clk);

    // DIV -7 / 2 = -3 rem -1
    launch(3'd2, 32'hFFFFFFF9, 32'h2);
    wait_done(n, d);
    chk("div_busy_cycles", 64'(n), 64'd10);
    chk("div_done", 64'(d), 64'h1);
    chk("div_lo", 64'(lo), 64'hFFFFFFFD);
    chk("div_hi", 64'(hi), 64'hFFFFFFFF);
    @(negedge clk);

    // DIVU 100 / 7 = 14 rem 2
    launch(3'd3, 32'd100, 32'd7);
    wait_done(n, d);
    chk("divu_lo", 64'(lo), 64'd14);
    chk("divu_hi", 64'(hi), 64'd2);
    @(negedge clk);

    // DIVU 7 / 0
    launch(3'd3, 32'd7, 32'd0);
    wait_done(n, d);
    chk("divz_lo", 64'(lo), 64'hFFFFFFFF);
    chk("divz_hi", 64'(hi), 64'd7);
    @(negedge clk);

    // DIV MIN / -1
    launch(3'd2, 32'h80000000, 32'hFFFFFFFF);
    wait_done(n, d);
    chk("divovf_lo", 64'(lo), 64'h80000000);
    chk("divovf_hi", 64'(hi), 64'h0);
    @(negedge clk);

    // MTHI single edge, no busy/done
    launch(3'd4, 32'h1234, 32'h0);
    chk("mthi_hi", 64'(hi), 64'h1234);
    chk("mthi_busy", 64'(busy), 64'h0);
    chk("mthi_done", 64'(done), 64'h0);

    // MULT, MTLO at busy cycle 2 (ignored), cancel at busy cycle 3
    launch(3'd0, 32'd3, 32'd4);
    @(posedge clk);
    #1 start = 1'b1; op = 3'd5; src_a = 32'h55;
    @(posedge clk);
    #1 start = 1'b0; cancel = 1'b1;
    @(posedge clk);
    #1 cancel = 1'b0;
    chk("cancel_busy", 64'(busy), 64'h0);
    chk("cancel_hi", 64'(hi), 64'h1234);
    chk("mtlo_ignored_lo", 64'(lo), 64'h80000000);
    seen_done = done;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      seen_done = seen_done | done;
    end
    chk("cancel_no_done", 64'(seen_done), 64'h0);
    chk("cancel_lo_kept", 64'(lo), 64'h80000000);

    // cancel together with start in IDLE: MTHI suppressed
    cancel = 1'b1;
    launch(3'd4, 32'h99, 32'h0);
    cancel = 1'b0;
    chk("cancel_idle_hi", 64'(hi), 64'h1234);
    chk("cancel_idle_busy", 64'(busy), 64'h0);
    @(negedge clk);

    // asynchronous reset in busy cycle 2 of a DIV
    launch(3'd2, 32'd100, 32'd7);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("areset_hi", 64'(hi), 64'h0);
    chk("areset_lo", 64'(lo), 64'h0);
    chk("areset_busy", 64'(busy), 64'h0);
    chk("areset_done", 64'(done), 64'h0);
    @(negedge clk) reset = 1'b1;
    @(negedge clk);
    launch(3'd2, 32'd100, 32'd7);
    wait_done(n, d);
    chk("post_reset_div_cycles", 64'(n), 64'd10);
    chk("post_reset_div_lo", 64'(lo), 64'd14);
    chk("post_reset_div_hi", 64'(hi), 64'd2);
    @(negedge clk);

    // accumulate ops
    launch(3'd5, 32'd10, 32'd0);
    launch(3'd4, 32'd0, 32'd0);
    chk("acc_pre_lo", 64'(lo), 64'd10);
    chk("acc_pre_hi", 64'(hi), 64'd0);
`ifdef MULDIV_MADD_EN
    launch(3'd6, 32'd3, 32'd4);
    wait_done(n, d);
    chk("madd_cycles", 64'(n), 64'd5);
    chk("madd_done", 64'(d), 64'h1);
    chk("madd_lo", 64'(lo), 64'd22);
    chk("madd_hi", 64'(hi), 64'd0);
    launch(3'd7, 32'd5, 32'd5);
    wait_done(n, d);
    chk("msub_hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
`else
    launch(3'd6, 32'd3, 32'd4);
    chk("op6_nop_busy", 64'(busy), 64'h0);
    launch(3'd7, 32'd5, 32'd5);
    chk("op7_nop_busy", 64'(busy), 64'h0);
    seen_done = done;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      seen_done = seen_done | done;
    end
    chk("op67_nop_done", 64'(seen_done), 64'h0);
    chk("op67_nop_lo", 64'(lo), 64'd10);
    chk("op67_nop_hi", 64'(hi), 64'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
